// File: rtl/wb_queue_stage.sv
// Write-back queue stage: FIFO between the cache stage and the register file with registered head outputs.
// Optional macro WB_BYPASS_EN adds a register lookup port across the occupied entries.
module wb_queue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int BP_W   = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          cache_result,
  input  logic [REG_AW-1:0]          destReg_addr_input,
  input  logic                       we_input,
  input  logic [BP_W-1:0]            bp_input,
  input  logic                       word_access_from_cache,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_result,
  output logic [REG_AW-1:0]          destReg_addr_output,
  output logic                       we_output,
  output logic [BP_W-1:0]            bp_output,
  output logic [$clog2(DEPTH):0]     count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]          bypass_addr,
  output logic                       bypass_hit,
  output logic [DATA_W-1:0]          bypass_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [REG_AW-1:0] r_mem_addr [DEPTH];
  logic              r_mem_we   [DEPTH];
  logic [BP_W-1:0]   r_mem_bp   [DEPTH];

  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_head_data;
  logic [REG_AW-1:0] r_head_addr;
  logic              r_head_we;
  logic [BP_W-1:0]   r_head_bp;

  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_in_data;
  logic [AW-1:0]     w_rd_ptr_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] w_head_data;
  logic [REG_AW-1:0] w_head_addr;
  logic              w_head_we;
  logic [BP_W-1:0]   w_head_bp;

  assign in_ready     = (r_count < CW'(DEPTH));
  assign wb_valid     = (r_count != '0);
  assign w_push       = in_valid & in_ready;
  assign w_pop        = wb_valid & wb_ready;
  assign w_in_data    = word_access_from_cache ? cache_result
                                               : {{(DATA_W-8){1'b0}}, cache_result[7:0]};
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);

  // Next head comes from the incoming entry when it lands in the slot the read pointer moves to.
  always_comb begin
    w_head_data = r_head_data;
    w_head_addr = r_head_addr;
    w_head_we   = r_head_we;
    w_head_bp   = r_head_bp;
    if (w_count_nxt != '0) begin
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_data = w_in_data;
        w_head_addr = destReg_addr_input;
        w_head_we   = we_input;
        w_head_bp   = bp_input;
      end else begin
        w_head_data = r_mem_data[w_rd_ptr_nxt];
        w_head_addr = r_mem_addr[w_rd_ptr_nxt];
        w_head_we   = r_mem_we[w_rd_ptr_nxt];
        w_head_bp   = r_mem_bp[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_data <= '0;
      r_head_addr <= '0;
      r_head_we   <= 1'b0;
      r_head_bp   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_head_data <= w_head_data;
      r_head_addr <= w_head_addr;
      r_head_we   <= w_head_we;
      r_head_bp   <= w_head_bp;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      r_mem_data[r_wr_ptr] <= w_in_data;
      r_mem_addr[r_wr_ptr] <= destReg_addr_input;
      r_mem_we[r_wr_ptr]   <= we_input;
      r_mem_bp[r_wr_ptr]   <= bp_input;
    end
  end

  assign wb_result           = r_head_data;
  assign destReg_addr_output = r_head_addr;
  assign we_output           = r_head_we & wb_valid;
  assign bp_output           = r_head_bp;
  assign count               = r_count;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [AW-1:0] w_idx;
    bypass_hit  = 1'b0;
    bypass_data = '0;
    w_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if ((CW'(i) < r_count) && r_mem_we[w_idx] && (r_mem_addr[w_idx] == bypass_addr)) begin
        bypass_hit  = 1'b1;
        bypass_data = r_mem_data[w_idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue_stage.sv
// Scoreboard bench for wb_queue_stage: a reference queue is updated from the driven inputs and compared at every falling edge.
module tb_wb_queue_stage;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  a;
    logic        we;
    logic [1:0]  bp;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] cache_result = '0;
  logic [2:0]  destReg_addr_input = '0;
  logic        we_input = 1'b0;
  logic [1:0]  bp_input = '0;
  logic        word_access_from_cache = 1'b1;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [15:0] wb_result;
  logic [2:0]  destReg_addr_output;
  logic        we_output;
  logic [1:0]  bp_output;
  logic [2:0]  count;
`ifdef WB_BYPASS_EN
  logic [2:0]  bypass_addr = '0;
  logic        bypass_hit;
  logic [15:0] bypass_data;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sb[$];
  ent_t last = '0;
  bit   armed = 1'b0;

  wb_queue_stage #(.DATA_W(16), .REG_AW(3), .BP_W(2), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .cache_result(cache_result), .destReg_addr_input(destReg_addr_input),
    .we_input(we_input), .bp_input(bp_input),
    .word_access_from_cache(word_access_from_cache),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
    .destReg_addr_output(destReg_addr_output), .we_output(we_output),
    .bp_output(bp_output), .count(count)
`ifdef WB_BYPASS_EN
    , .bypass_addr(bypass_addr), .bypass_hit(bypass_hit), .bypass_data(bypass_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare state from the previous edge, then advance the reference for the coming edge.
  always @(negedge clk) begin
    ent_t e;
    bit   push_ok;
    if (armed) begin
      check("count", 32'(count), 32'(sb.size()));
      check("in_ready", 32'(in_ready), 32'(sb.size() < 4));
      check("wb_valid", 32'(wb_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
        check("head_data", 32'(wb_result), 32'(sb[0].d));
        check("head_addr", 32'(destReg_addr_output), 32'(sb[0].a));
        check("head_we", 32'(we_output), 32'(sb[0].we));
        check("head_bp", 32'(bp_output), 32'(sb[0].bp));
        last = sb[0];
      end else begin
        check("idle_we", 32'(we_output), 32'd0);
        check("hold_data", 32'(wb_result), 32'(last.d));
        check("hold_addr", 32'(destReg_addr_output), 32'(last.a));
        check("hold_bp", 32'(bp_output), 32'(last.bp));
      end
    end
    if (reset) begin
      sb.delete();
      last  = '0;
      armed = 1'b1;
    end else if (flush) begin
      sb.delete();
    end else begin
      push_ok = in_valid && (sb.size() < 4);
      if (sb.size() > 0 && wb_ready) void'(sb.pop_front());
      if (push_ok) begin
        e.d  = word_access_from_cache ? cache_result : {8'h00, cache_result[7:0]};
        e.a  = destReg_addr_input;
        e.we = we_input;
        e.bp = bp_input;
        sb.push_back(e);
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] d, input logic [2:0] a, input logic we,
                     input logic [1:0] bp, input logic word, input logic rdy, input logic fl);
    in_valid = v; cache_result = d; destReg_addr_input = a; we_input = we;
    bp_input = bp; word_access_from_cache = word; wb_ready = rdy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 16'h0, 3'd0, 1'b0, 2'd0, 1'b1, rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_result", 32'(wb_result), 32'd0);

    cyc(1'b1, 16'h1234, 3'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
    check("lat_valid", 32'(wb_valid), 32'd1);
    check("lat_data", 32'(wb_result), 32'h1234);
    check("lat_addr", 32'(destReg_addr_output), 32'd3);
    idle(1'b1);
    check("lat_count0", 32'(count), 32'd0);

    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'h0100 + 16'(i), 3'(i), 1'(i % 2), 2'(i), 1'b1, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    cyc(1'b1, 16'hDEAD, 3'd7, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    check("full_push_ignored", 32'(count), 32'd4);
    check("full_head_kept", 32'(wb_result), 32'h0100);
    repeat (4) idle(1'b1);
    check("drain_empty", 32'(wb_valid), 32'd0);
    check("drain_hold", 32'(wb_result), 32'h0103);

    cyc(1'b1, 16'hABCD, 3'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    check("byte_zext", 32'(wb_result), 32'h00CD);
    idle(1'b1);

    for (int i = 0; i < 4; i++)
      cyc(1'b1, 16'h0200 + 16'(i), 3'(i + 2), 1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0BAD, 3'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    check("full_pushpop", 32'(count), 32'd3);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0300 + 16'(i), 3'(i), 1'b1, 2'd1, 1'b1, 1'b1, 1'b0);
      check("pushpop_count2", 32'(count), 32'd2);
    end
    repeat (2) idle(1'b1);

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'h0400 + 16'(i), 3'd4, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    cyc(1'b1, 16'h0500, 3'd5, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(wb_valid), 32'd0);
    cyc(1'b1, 16'h0600, 3'd6, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 16'h0700, 3'd7, 1'b1, 2'd3, 1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    check("rstfl_count", 32'(count), 32'd0);
    check("rstfl_in_ready", 32'(in_ready), 32'd1);
    check("rstfl_valid", 32'(wb_valid), 32'd0);
    check("rstfl_we", 32'(we_output), 32'd0);
    check("rstfl_data", 32'(wb_result), 32'd0);
    check("rstfl_addr", 32'(destReg_addr_output), 32'd0);
    check("rstfl_bp", 32'(bp_output), 32'd0);

    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 1'($urandom),
          2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));

`ifdef WB_BYPASS_EN
    cyc(1'b0, 16'h0, 3'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'h0011, 3'd5, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h0022, 3'd5, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    bypass_addr = 3'd5;
    #1;
    check("byp_hit", 32'(bypass_hit), 32'd1);
    check("byp_data", 32'(bypass_data), 32'h0022);
    bypass_addr = 3'd6;
    #1;
    check("byp_miss", 32'(bypass_hit), 32'd0);
`endif
    repeat (5) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
